div_unit: RTL
=============

# div_unit

Sequential 32-bit signed integer divider for the multicycle MIPS datapath. It takes the dividend and divisor from the A/B operand path, iterates one quotient bit per clock, and delivers the remainder on HI and the quotient on LO for the HI/LO registers. It reports divide-by-zero to the control unit, which uses it to raise the exception. A start/done handshake lets the control FSM stall in its DIV wait state.

## Interface
Parameters:
- DATA_W, 32: operand and result width. Only 32 is supported.

Ports:
- clock  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low; clears all state and outputs.
- div_start  in  1  request; sampled only in IDLE.
- A  in  32  dividend (signed, two's complement).
- B  in  32  divisor (signed, two's complement).
- HI  out  32  remainder, registered.
- LO  out  32  quotient, registered.
- busy  out  1  high while a division is in progress.
- div_done  out  1  one-cycle pulse when a result or error is available.
- div_zero  out  1  divide-by-zero flag, registered.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE**, div_start=1, B≠0:
  - Capture |A| and |B|, sign_q = A[31]^B[31], sign_r = A[31].
  - Clear the partial remainder and cnt, clear div_zero, set busy, go to CALC.
- **IDLE**, div_start=1, B=0:
  - Set div_zero=1 and div_done=1, go to DONE.
  - HI and LO keep their previous values.
- **CALC**: one restoring step per cycle.
  - rem = {rem[30:0], q[31]}, q = q<<1.
  - If rem ≥ |B|: rem -= |B| and q[0] = 1.
  - cnt increments. After the step with cnt=31, go to FIX.
- **FIX**:
  - LO = sign_q ? -q : q.
  - HI = sign_r ? -rem : rem.
  - div_done=1, busy=0, go to DONE.
- **DONE**: div_done=0, go to IDLE.
- Arithmetic: magnitudes are computed as 32-bit unsigned. |0x80000000| = 0x80000000, so the result of 0x80000000 / 0xFFFFFFFF comes out naturally as LO=0x80000000, HI=0, with no overflow flag.
- The quotient truncates toward zero, and the remainder takes the sign of the dividend (MIPS DIV semantics).
- A and B are captured at acceptance. Later changes have no effect on the running operation.
- div_start in any state other than IDLE is ignored. It is neither queued nor an error.
- HI and LO change only in FIX. They hold until the next successful division.
- div_zero holds until the next accepted div_start.

## Timing
- Reset values: HI=0, LO=0, busy=0, div_done=0, div_zero=0, state=IDLE, cnt=0.
- Normal division, div_start sampled at edge N:
  - busy is high from after edge N until edge N+33.
  - HI, LO and div_done update at edge N+33.
  - div_done is high for exactly one cycle, N+33 to N+34.
  - The earliest next accept is edge N+35.
- Divide by zero, accepted at edge N:
  - div_zero=1 and div_done=1 from edge N.
  - div_done drops at edge N+1. busy never rises.
- Reset asserted mid-CALC aborts immediately and asynchronously. No div_done pulse is produced, and HI/LO go to 0.
- Deassertion is synchronous to the design's reset synchronizer; the block itself needs no special handling.

## Structure
- Package div_pkg holds:
  - the state enum (IDLE, CALC, FIX, DONE);
  - DATA_W = 32;
  - CNT_W = 5.
- Sub-module div_step is combinational. It performs one restoring iteration: in rem, q, divisor; out rem', q'.
- The FSM, counter and registers live in div_unit.

## Test plan
- A=100, B=7, start at edge N: LO=14, HI=2, div_done a single pulse at N+33, busy high for cycles N..N+32.
- A=-7 (0xFFFFFFF9), B=2: LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Then A=7, B=-2: LO=0xFFFFFFFD, HI=1.
- After a prior result HI=2/LO=14, apply A=5, B=0: div_zero=1 and div_done pulse at the accept edge, HI=2/LO=14 unchanged. A following valid start clears div_zero.
- A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0, div_zero=0. Also A=0, B=-5: LO=0, HI=0.
- Start a division, then pulse div_start again with new A/B at cycle 10: result matches the first operands, and only one div_done is produced.
- Assert reset at cycle 10 of CALC: busy=0, HI=0, LO=0, no div_done. After release, a fresh 100/7 completes correctly.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? -v : v;
    endfunction
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] q,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_nxt,
    output logic [DATA_W-1:0] q_nxt
);
    // One extra bit keeps the compare exact even for a 0x80000000 divisor.
    logic [DATA_W:0] shifted;

    always_comb begin
        shifted = {rem, q[DATA_W-1]};
        if (shifted >= {1'b0, divisor}) begin
            rem_nxt = shifted[DATA_W-1:0] - divisor;
            q_nxt   = {q[DATA_W-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[DATA_W-1:0];
            q_nxt   = {q[DATA_W-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/div_unit.sv
// Sequential 32-bit signed divider, one quotient bit per clock; remainder on HI, quotient on LO.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              div_start,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO,
    output logic              busy,
    output logic              div_done,
    output logic              div_zero
);
    import div_pkg::*;

    div_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem, q, mag_b;
    logic [DATA_W-1:0] rem_nxt, q_nxt;
    logic              sign_q, sign_r;
    logic              b_is_zero;

    assign b_is_zero = (B == '0);

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem     (rem),
        .q       (q),
        .divisor (mag_b),
        .rem_nxt (rem_nxt),
        .q_nxt   (q_nxt)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (div_start) state_nxt = b_is_zero ? DONE : CALC;
            CALC: if (cnt == '1) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs; divide-by-zero skips CALC/FIX so HI/LO stay put.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            rem      <= '0;
            q        <= '0;
            mag_b    <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            HI       <= '0;
            LO       <= '0;
            busy     <= 1'b0;
            div_done <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (div_start) begin
                    if (b_is_zero) begin
                        div_zero <= 1'b1;
                        div_done <= 1'b1;
                    end else begin
                        div_zero <= 1'b0;
                        q        <= abs_val(A);
                        mag_b    <= abs_val(B);
                        rem      <= '0;
                        cnt      <= '0;
                        sign_q   <= A[DATA_W-1] ^ B[DATA_W-1];
                        sign_r   <= A[DATA_W-1];
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    q   <= q_nxt;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    LO       <= sign_q ? -q : q;
                    HI       <= sign_r ? -rem : rem;
                    div_done <= 1'b1;
                    busy     <= 1'b0;
                end
                DONE: div_done <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
